// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Address bits [31:28] select one of 16 pages of 256 MB.
    localparam int PAGE_W = 4;

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } dflt_state_t;

endpackage

// File: rtl/ahbl_default_slave.sv
// Built-in default slave: answers unmapped accesses with the two-cycle
// AHB-Lite ERROR response.
//
// state   | meaning
// --------+---------------------------------------------------------
// DS_OK   | idle, zero-wait OKAY (HREADYOUT=1, HRESP=0)
// DS_ERR1 | first ERROR cycle, stall the master (HREADYOUT=0, HRESP=1)
// DS_ERR2 | second ERROR cycle, complete it (HREADYOUT=1, HRESP=1)
module ahbl_default_slave
    import ahbl_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic accept_miss,
    output logic HREADYOUT,
    output logic HRESP
);

    dflt_state_t state;

    // State and registered outputs advance together; ERR1 always moves on,
    // even if the master cancels its pending transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= DS_OK;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else begin
            case (state)
                DS_OK: begin
                    if (accept_miss) begin
                        state     <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    if (accept_miss) begin
                        state     <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= HRESP_ERROR;
                    end else begin
                        state     <= DS_OK;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
                default: begin
                    state     <= DS_OK;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahbl_splitter_n.sv
// N-port AHB-Lite splitter: page decode on HADDR[31:28] into one-hot
// selects, data-phase response mux, and a built-in default slave for
// unmapped pages.
module ahbl_splitter_n
    import ahbl_pkg::*;
#(
    parameter int                   NS       = 4,
    parameter int                   DW       = 32,
    parameter logic [NS*PAGE_W-1:0] PAGE_MAP = {4'h8, 4'h4, 4'h2, 4'h0},
    parameter logic [31:0]          ERR_DATA = 32'hBADDBEEF
)(
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic             HREADY,
    output logic [DW-1:0]    HRDATA,
    output logic             HRESP,
    output logic [NS-1:0]    S_HSEL,
    input  logic [NS*DW-1:0] S_HRDATA,
    input  logic [NS-1:0]    S_HREADYOUT,
    input  logic [NS-1:0]    S_HRESP
);

    localparam logic [DW-1:0] ERR_DATA_DW = DW'(ERR_DATA);

    logic [NS-1:0] sel_d;
    logic          dflt_d;
    logic          hit;
    logic          accept_miss;
    logic          ds_ready;
    logic          ds_resp;
    logic          unused_bits;

    // Only the page bits take part in decode; the low address bits and
    // the SEQ/NONSEQ distinction are irrelevant here.
    assign unused_bits = ^{HADDR[27:0], HTRANS[0]};

    // Page decode; the first matching slot claims the page so duplicate
    // page IDs never produce more than one select.
    always_comb begin
        S_HSEL = '0;
        hit    = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!hit && (HADDR[31:28] == PAGE_MAP[i*PAGE_W +: PAGE_W])) begin
                S_HSEL[i] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    assign accept_miss = HTRANS[1] & HREADY & ~hit;

    // Capture the data-phase owner whenever the bus is ready; IDLE/BUSY
    // leave nobody selected so they complete as zero-wait OKAY.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_d  <= '0;
            dflt_d <= 1'b0;
        end else if (HREADY) begin
            if (HTRANS[1]) begin
                sel_d  <= S_HSEL;
                dflt_d <= ~hit;
            end else begin
                sel_d  <= '0;
                dflt_d <= 1'b0;
            end
        end
    end

    ahbl_default_slave u_default_slave (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .accept_miss (accept_miss),
        .HREADYOUT   (ds_ready),
        .HRESP       (ds_resp)
    );

    // Data-phase response mux; sel_d is one-hot or zero.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = ERR_DATA_DW;
        if (dflt_d) begin
            HREADY = ds_ready;
            HRESP  = ds_resp;
        end
        for (int i = 0; i < NS; i++) begin
            if (sel_d[i]) begin
                HREADY = S_HREADYOUT[i];
                HRESP  = S_HRESP[i];
                HRDATA = S_HRDATA[DW*i +: DW];
            end
        end
    end

endmodule
